// File: rtl/arith_pkg.sv
// Shared arithmetic-lab definitions: FSM state encoding and default width.
package arith_pkg;

    // Default operand/result width for the arithmetic lab datapath.
    localparam int DEFAULT_WIDTH = 8;

    // Handshake FSM states for the serial arithmetic blocks.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage : arith_pkg

// File: rtl/full_subtractor_1bit.sv
// One-bit full subtractor: d = x - y - bin, with borrow-out.
module full_subtractor_1bit (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    // Difference bit and borrow-out of a single bit position.
    assign d    = x ^ y ^ bin;
    assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule : full_subtractor_1bit

// File: rtl/serial_subtractor_8bit.sv
// Bit-serial subtractor: diff = a - b, one bit per clock, LSB first.
// Results are held in dedicated registers so they stay stable while the
// next operation is shifting through the working registers.
module serial_subtractor_8bit
    import arith_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             overflow
);

    // One extra bit so the counter never wraps before the last bit is seen.
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             bin_q, bin_d;
    logic             amsb_q, amsb_d;
    logic             bmsb_q, bmsb_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_q, borrow_d;
    logic             ovf_q, ovf_d;

    logic             fs_d;
    logic             fs_bout;
    logic [WIDTH-1:0] res_shifted;

    full_subtractor_1bit u_fs (
        .x    (sa_q[0]),
        .y    (sb_q[0]),
        .bin  (bin_q),
        .d    (fs_d),
        .bout (fs_bout)
    );

    // New difference bit enters at the MSB end so bit 0 lands at position 0
    // after WIDTH shifts.
    assign res_shifted = {fs_d, res_q[WIDTH-1:1]};

    // Next-state, datapath and result-capture logic.
    always_comb begin
        state_d  = state_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        res_d    = res_q;
        cnt_d    = cnt_q;
        bin_d    = bin_q;
        amsb_d   = amsb_q;
        bmsb_d   = bmsb_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
        ovf_d    = ovf_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    sa_d    = a;
                    sb_d    = b;
                    bin_d   = 1'b0;
                    cnt_d   = '0;
                    amsb_d  = a[WIDTH-1];
                    bmsb_d  = b[WIDTH-1];
                    state_d = ST_SHIFT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                // start is deliberately ignored here: no restart, no queuing.
                res_d = res_shifted;
                sa_d  = sa_q >> 1;
                sb_d  = sb_q >> 1;
                bin_d = fs_bout;
                cnt_d = cnt_q + CNT_ONE;
                if (cnt_q == CNT_LAST) begin
                    state_d  = ST_DONE;
                    diff_d   = res_shifted;
                    borrow_d = fs_bout;
                    ovf_d    = (amsb_q != bmsb_q) && (fs_d != amsb_q);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            sa_q     <= '0;
            sb_q     <= '0;
            res_q    <= '0;
            cnt_q    <= '0;
            bin_q    <= 1'b0;
            amsb_q   <= 1'b0;
            bmsb_q   <= 1'b0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            res_q    <= res_d;
            cnt_q    <= cnt_d;
            bin_q    <= bin_d;
            amsb_q   <= amsb_d;
            bmsb_q   <= bmsb_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
            ovf_q    <= ovf_d;
        end
    end

    // Status flags decode directly from the state register.
    assign busy     = (state_q == ST_SHIFT);
    assign done     = (state_q == ST_DONE);
    assign diff     = diff_q;
    assign borrow   = borrow_q;
    assign overflow = ovf_q;

endmodule : serial_subtractor_8bit
